load_store_unit: RTL and testbench

Memory-access stage of the 24-bit CPU, directly upstream of DataMemory. Accepts one load/store/pass-through request from the execute stage over a valid/ready handshake and drives DataMemory's Adresa, WriteData, MemWrite and MemRead for exactly one cycle per memory operation. Captures ReadData and presents the result to writeback over a second valid/ready handshake. Range-checks addresses against the memory depth and flags illegal accesses instead of touching memory.

---
 rtl/cpu24_pkg.sv | 19 +
 rtl/DataMemory.sv | 26 ++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU datapath: widths, op codes and LSU FSM states.
package cpu24_pkg;
  localparam int DATA_W    = 24;
  localparam int RD_W      = 4;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    OP_PASS    = 2'b00,
    OP_LOAD    = 2'b01,
    OP_STORE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;
endpackage

// File: rtl/DataMemory.sv
// Word-addressed data RAM: combinational read of Adresa, write on the rising Clock edge.
// Latency: read 0 cycles, write lands at the edge closing the MemWrite cycle; no backpressure.
module DataMemory #(
  parameter int DATA_W    = cpu24_pkg::DATA_W,
  parameter int MEM_DEPTH = cpu24_pkg::MEM_DEPTH
) (
  input  logic              Clock,
  input  logic [DATA_W-1:0] Adresa,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [DATA_W-1:0] ReadData
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic              unused_bits;

  // Only the low index bits decode; range checking belongs to the requester.
  assign unused_bits = ^{Adresa[DATA_W-1:AW], MemRead};
  assign ReadData    = mem_q[Adresa[AW-1:0]];

  always_ff @(posedge Clock) begin
    if (MemWrite) mem_q[Adresa[AW-1:0]] <= WriteData;
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request in, one DataMemory strobe, one writeback result; accept to wb_valid is 1 cycle.
// Backpressure: ex_ready low in ACCESS and in RESP until wb_ready; results held stable while wb_ready is low.
module load_store_unit #(
  parameter int DATA_W    = cpu24_pkg::DATA_W,
  parameter int MEM_DEPTH = cpu24_pkg::MEM_DEPTH,
  parameter int RD_W      = cpu24_pkg::RD_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] Adresa,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic              wb_fault
);
  import cpu24_pkg::*;

  localparam logic [DATA_W-1:0] DEPTH = DATA_W'(MEM_DEPTH);

  lsu_state_e        state_q;
  logic              req_vld_q;
  logic [1:0]        req_op_q;
  logic [DATA_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [RD_W-1:0]   req_rd_q;
  logic              req_fault_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic              wb_we_q;
  logic              wb_fault_q;

  logic              accept;
  logic              in_access;
  logic              req_fault_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_we_d;

  assign ex_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && wb_ready);
  assign accept   = ex_valid && ex_ready;

  // Unsigned full-width compare so any upper address bit set is out of range.
  assign req_fault_d = (ex_op == OP_ILLEGAL) ||
                       (((ex_op == OP_LOAD) || (ex_op == OP_STORE)) && (ex_addr >= DEPTH));

  // Strobes decode straight from state so an async reset drops them immediately.
  assign in_access = (state_q == ST_ACCESS);
  assign MemRead   = in_access && (req_op_q == OP_LOAD)  && !req_fault_q;
  assign MemWrite  = in_access && (req_op_q == OP_STORE) && !req_fault_q;
  assign WriteData = MemWrite ? req_wdata_q : '0;
  assign Adresa    = req_vld_q ? req_addr_q : '0;

  always_comb begin
    wb_data_d = '0;
    if (!req_fault_q) begin
      if (req_op_q == OP_LOAD)      wb_data_d = ReadData;
      else if (req_op_q == OP_PASS) wb_data_d = req_addr_q;
    end
  end

  assign wb_we_d = !req_fault_q && ((req_op_q == OP_LOAD) || (req_op_q == OP_PASS));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      req_vld_q   <= 1'b0;
      req_op_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_rd_q    <= '0;
      req_fault_q <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        req_vld_q   <= 1'b1;
        req_op_q    <= ex_op;
        req_addr_q  <= ex_addr;
        req_wdata_q <= ex_wdata;
        req_rd_q    <= ex_rd;
        req_fault_q <= req_fault_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          wb_data_q  <= wb_data_d;
          wb_rd_q    <= req_rd_q;
          wb_we_q    <= wb_we_d;
          wb_fault_q <= req_fault_q;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (wb_ready) begin
            if (accept) begin
              state_q <= ST_ACCESS;
            end else begin
              state_q   <= ST_IDLE;
              req_vld_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_valid = (state_q == ST_RESP);
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_we    = wb_we_q;
  assign wb_fault = wb_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit driving the real DataMemory.
module tb_load_store_unit;
  import cpu24_pkg::*;

  localparam int DW    = 24;
  localparam int RW    = 4;
  localparam int DEPTH = 256;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          ex_valid, ex_ready;
  logic [1:0]    ex_op;
  logic [DW-1:0] ex_addr, ex_wdata;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] Adresa, WriteData, ReadData;
  logic          MemWrite, MemRead;
  logic          wb_valid, wb_ready;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_we, wb_fault;

  always #5 Clock = ~Clock;

  load_store_unit #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .RD_W(RW)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .Adresa(Adresa), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .ReadData(ReadData),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_fault(wb_fault)
  );

  DataMemory #(.DATA_W(DW), .MEM_DEPTH(DEPTH)) u_mem (
    .Clock(Clock), .Adresa(Adresa), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
  );

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic [DW-1:0] exp_data;
    logic          exp_we;
    logic          exp_fault;
    int            exp_rd_n;
    int            exp_wr_n;
  } vec_t;

  int checks = 0, failures = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, cycle = 0;
  logic [DW-1:0] last_wr_addr = '0, last_wr_data = '0;
  int acc_cyc[$];
  vec_t vecs[13];

  always @(posedge Clock) cycle++;

  // Strobes and handshakes are stable mid-cycle, so observe them on the falling edge.
  always @(negedge Clock) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) begin
      wr_cnt++;
      last_wr_addr = Adresa;
      last_wr_data = WriteData;
    end
    if (MemRead && MemWrite) both_cnt++;
    if (Reset_n && ex_valid && ex_ready) acc_cyc.push_back(cycle);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ex_ready && n < 20) begin
      tick();
      n++;
    end
    chk(name, {31'd0, ex_ready}, 32'd1);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [RW-1:0] rd, input logic [DW-1:0] d, input logic we,
                              input logic f, input int nr, input int nw);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.exp_data = d; v.exp_we = we; v.exp_fault = f; v.exp_rd_n = nr; v.exp_wr_n = nw;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    int rd0, wr0;
    wait_ready($sformatf("v%0d_ready", i));
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    ex_op = v.op; ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    tick();
    chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
    chk($sformatf("v%0d_wb_data", i), {8'd0, wb_data}, {8'd0, v.exp_data});
    chk($sformatf("v%0d_wb_rd", i), {28'd0, wb_rd}, {28'd0, v.rd});
    chk($sformatf("v%0d_wb_we", i), {31'd0, wb_we}, {31'd0, v.exp_we});
    chk($sformatf("v%0d_wb_fault", i), {31'd0, wb_fault}, {31'd0, v.exp_fault});
    chk($sformatf("v%0d_memread_n", i), rd_cnt - rd0, v.exp_rd_n);
    chk($sformatf("v%0d_memwrite_n", i), wr_cnt - wr0, v.exp_wr_n);
    if (v.exp_wr_n == 1) begin
      chk($sformatf("v%0d_wr_addr", i), {8'd0, last_wr_addr}, {8'd0, v.addr});
      chk($sformatf("v%0d_wr_data", i), {8'd0, last_wr_data}, {8'd0, v.wdata});
    end
    tick();
  endtask

  initial begin
    int rd0, wr0;
    vec_t bb[4];
    vec_t v;

    vecs[0]  = mk(OP_STORE,   24'd3,       24'd14,      4'd1,  24'd0,       1'b0, 1'b0, 0, 1);
    vecs[1]  = mk(OP_LOAD,    24'd3,       24'd0,       4'd5,  24'd14,      1'b1, 1'b0, 1, 0);
    vecs[2]  = mk(OP_STORE,   24'd0,       24'h00AA55,  4'd2,  24'd0,       1'b0, 1'b0, 0, 1);
    vecs[3]  = mk(OP_STORE,   24'd255,     24'h123456,  4'd2,  24'd0,       1'b0, 1'b0, 0, 1);
    vecs[4]  = mk(OP_LOAD,    24'd255,     24'd0,       4'd7,  24'h123456,  1'b1, 1'b0, 1, 0);
    vecs[5]  = mk(OP_STORE,   24'd256,     24'hFFFFFF,  4'd3,  24'd0,       1'b0, 1'b1, 0, 0);
    vecs[6]  = mk(OP_LOAD,    24'd0,       24'd0,       4'd4,  24'h00AA55,  1'b1, 1'b0, 1, 0);
    vecs[7]  = mk(OP_STORE,   24'h800003,  24'd77,      4'd3,  24'd0,       1'b0, 1'b1, 0, 0);
    vecs[8]  = mk(OP_LOAD,    24'd3,       24'd0,       4'd6,  24'd14,      1'b1, 1'b0, 1, 0);
    vecs[9]  = mk(OP_ILLEGAL, 24'd5,       24'd9,       4'd8,  24'd0,       1'b0, 1'b1, 0, 0);
    vecs[10] = mk(OP_PASS,    24'hABCDEF,  24'd0,       4'd9,  24'hABCDEF,  1'b1, 1'b0, 0, 0);
    vecs[11] = mk(OP_LOAD,    24'd256,     24'd0,       4'd10, 24'd0,       1'b0, 1'b1, 0, 0);
    vecs[12] = mk(OP_STORE,   24'd20,      24'h000F0F,  4'd1,  24'd0,       1'b0, 1'b0, 0, 1);

    Reset_n = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    wb_ready = 1'b1;
    #12;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", {8'd0, wb_data}, 32'd0);
    chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_fault", {31'd0, wb_fault}, 32'd0);
    chk("rst_adresa", {8'd0, Adresa}, 32'd0);
    chk("rst_writedata", {8'd0, WriteData}, 32'd0);
    chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    Reset_n = 1'b1;
    tick();
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Writeback stalled for 3 cycles with a competing request on ex_*.
    wb_ready = 1'b0;
    wait_ready("bp_ready");
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    ex_op = OP_LOAD; ex_addr = 24'd3; ex_rd = 4'd5; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    chk("bp_ex_ready_access", {31'd0, ex_ready}, 32'd0);
    tick();
    ex_op = OP_STORE; ex_addr = 24'd3; ex_wdata = 24'd99; ex_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_wb_valid", k), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("bp%0d_wb_data", k), {8'd0, wb_data}, 32'd14);
      chk($sformatf("bp%0d_ex_ready", k), {31'd0, ex_ready}, 32'd0);
      tick();
    end
    ex_valid = 1'b0;
    chk("bp_wb_valid_end", {31'd0, wb_valid}, 32'd1);
    chk("bp_memread_n", rd_cnt - rd0, 32'd1);
    chk("bp_memwrite_n", wr_cnt - wr0, 32'd0);
    wb_ready = 1'b1;
    #1;
    chk("bp_ex_ready_release", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("bp_idle_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Back-to-back: ex_valid held across four requests, store then dependent load.
    bb[0] = mk(OP_STORE, 24'd10,   24'h000111, 4'd0, 24'd0,       1'b0, 1'b0, 0, 1);
    bb[1] = mk(OP_LOAD,  24'd10,   24'd0,      4'd1, 24'h000111,  1'b1, 1'b0, 1, 0);
    bb[2] = mk(OP_PASS,  24'h55,   24'd0,      4'd2, 24'h55,      1'b1, 1'b0, 0, 0);
    bb[3] = mk(OP_LOAD,  24'd3,    24'd0,      4'd3, 24'd14,      1'b1, 1'b0, 1, 0);
    wait_ready("bb_ready");
    acc_cyc.delete();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    both_cnt = 0;
    ex_op = bb[0].op; ex_addr = bb[0].addr; ex_wdata = bb[0].wdata; ex_rd = bb[0].rd; ex_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bb%0d_ex_ready_access", k), {31'd0, ex_ready}, 32'd0);
      tick();
      chk($sformatf("bb%0d_wb_valid", k), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("bb%0d_wb_data", k), {8'd0, wb_data}, {8'd0, bb[k].exp_data});
      chk($sformatf("bb%0d_wb_rd", k), {28'd0, wb_rd}, {28'd0, bb[k].rd});
      chk($sformatf("bb%0d_wb_we", k), {31'd0, wb_we}, {31'd0, bb[k].exp_we});
      if (k < 3) begin
        ex_op = bb[k+1].op; ex_addr = bb[k+1].addr; ex_wdata = bb[k+1].wdata; ex_rd = bb[k+1].rd;
      end else begin
        ex_valid = 1'b0;
      end
    end
    tick();
    chk("bb_accept_n", acc_cyc.size(), 32'd4);
    if (acc_cyc.size() == 4)
      for (int k = 1; k < 4; k++)
        chk($sformatf("bb%0d_accept_gap", k), acc_cyc[k] - acc_cyc[k-1], 32'd2);
    chk("bb_memread_n", rd_cnt - rd0, 32'd2);
    chk("bb_memwrite_n", wr_cnt - wr0, 32'd1);
    chk("bb_both_strobes", both_cnt, 32'd0);

    // Reset during a store's ACCESS cycle must abort the write.
    wait_ready("rm_ready");
    wr0 = wr_cnt;
    ex_op = OP_STORE; ex_addr = 24'd20; ex_wdata = 24'h00BEEF; ex_rd = 4'd1; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    chk("rm_memwrite_before", {31'd0, MemWrite}, 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rm_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rm_memread", {31'd0, MemRead}, 32'd0);
    chk("rm_adresa", {8'd0, Adresa}, 32'd0);
    chk("rm_writedata", {8'd0, WriteData}, 32'd0);
    chk("rm_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rm_wb_data", {8'd0, wb_data}, 32'd0);
    #1;
    Reset_n = 1'b1;
    tick();
    chk("rm_post_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rm_post_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rm_no_write", wr_cnt - wr0, 32'd0);
    v = mk(OP_LOAD, 24'd20, 24'd0, 4'd11, 24'h000F0F, 1'b1, 1'b0, 1, 0);
    run_vec(20, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
